bcd_serial_addsub: RTL

Sequential signed BCD add/subtract engine for sign-magnitude operands of NDIG decimal digits (default 3 digits, range -999..+999). It time-shares a single one-digit BCD adder and processes one digit per clock, least significant digit first. When an effective subtraction gives a negative result, it runs a second ten's-complement pass over the same adder. It is the sequencing controller that sits in front of the per-digit 4-bit adder datapath of the signed BCD adder/subtractor.

---
 rtl/bcd_serial_addsub_pkg.sv | 33 +++
 rtl/bcd_serial_addsub_if.sv | 38 +++
 rtl/bcd_serial_addsub_adder.sv | 29 ++
 rtl/bcd_serial_addsub.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_addsub_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared types and constants for the serial signed BCD add/sub engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam int DIGIT_W  = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  // Digit counter width; never narrower than one bit so NDIG=1 still builds.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_serial_addsub_if.sv
// ============================================================================
// Module  : bcd_serial_addsub_if
// Brief   : Request/operand/result bundle of the serial signed BCD add/sub engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_serial_addsub_if #(
  parameter int NDIG = 3
);
  localparam int W = 4 * NDIG;

  logic         start;
  logic         op;
  logic         a_sign;
  logic [W-1:0] a_mag;
  logic         b_sign;
  logic [W-1:0] b_mag;
  logic         busy;
  logic         done;
  logic         r_sign;
  logic [W-1:0] r_mag;
  logic         overflow;
  logic         err;

  modport master (
    output start, op, a_sign, a_mag, b_sign, b_mag,
    input  busy, done, r_sign, r_mag, overflow, err
  );

  modport slave (
    input  start, op, a_sign, a_mag, b_sign, b_mag,
    output busy, done, r_sign, r_mag, overflow, err
  );

endinterface

`default_nettype wire

// File: rtl/bcd_serial_addsub_adder.sv
// ============================================================================
// Module  : bcd_digit_adder
// Brief   : Combinational one-digit BCD adder with decimal carry correction.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);

  logic [DIGIT_W:0] sum;

  always_comb begin
    sum  = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, cin};
    cout = (sum > (DIGIT_W+1)'(BCD_MAX));
    // Adding 6 modulo 16 gives the low digit of the corrected sum.
    s    = cout ? (sum[DIGIT_W-1:0] + DIGIT_W'(BCD_CORR)) : sum[DIGIT_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_addsub.sv
// ============================================================================
// Module  : bcd_serial_addsub
// Brief   : Digit-serial signed BCD add/subtract controller, LSD first, with a
//           ten's-complement second pass for negative effective subtractions.
//           Optional macro BCD_INPUT_CHECK_EN enables non-BCD input rejection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int NDIG = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_serial_addsub_if.slave   bus
);

  localparam int W  = DIGIT_W * NDIG;
  localparam int CW = clog2(NDIG);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_sign_q, a_sign_d;
  logic [W-1:0]  a_mag_q, a_mag_d;
  logic [W-1:0]  b_mag_q, b_mag_d;
  logic          eff_q, eff_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  r_mag_q, r_mag_d;
  logic          r_sign_q, r_sign_d;
  logic          overflow_q, overflow_d;
  logic          err_q, err_d;

  logic [DIGIT_W-1:0] dig_a, dig_b, dig_r;
  logic [DIGIT_W-1:0] add_x, add_y, add_s;
  logic               add_cout;
  logic               last_dig;
  logic               in_bad;

`ifdef BCD_INPUT_CHECK_EN
  logic [NDIG-1:0] bad_dig;
  for (genvar i = 0; i < NDIG; i++) begin : g_chk
    assign bad_dig[i] = (bus.a_mag[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) ||
                        (bus.b_mag[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX));
  end
  assign in_bad = |bad_dig;
`else
  assign in_bad = 1'b0;
`endif

  assign dig_a    = a_mag_q[cnt_q*DIGIT_W +: DIGIT_W];
  assign dig_b    = b_mag_q[cnt_q*DIGIT_W +: DIGIT_W];
  assign dig_r    = r_mag_q[cnt_q*DIGIT_W +: DIGIT_W];
  assign last_dig = (cnt_q == CW'(NDIG-1));

  // P2 re-complements the stored digit; P1 adds A to B or its nine's complement.
  always_comb begin
    add_x = dig_a;
    add_y = eff_q ? (DIGIT_W'(BCD_MAX) - dig_b) : dig_b;
    if (state_q == P2) begin
      add_x = DIGIT_W'(BCD_MAX) - dig_r;
      add_y = '0;
    end
  end

  bcd_digit_adder u_adder (
    .x    (add_x),
    .y    (add_y),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_cout)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_sign_d   = a_sign_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    eff_d      = eff_q;
    carry_d    = carry_q;
    r_mag_d    = r_mag_q;
    r_sign_d   = r_sign_q;
    overflow_d = overflow_q;
    err_d      = err_q;

    case (state_q)
      IDLE, FIN: begin
        if (bus.start) begin
          a_sign_d   = bus.a_sign;
          a_mag_d    = bus.a_mag;
          b_mag_d    = bus.b_mag;
          eff_d      = bus.a_sign ^ bus.b_sign ^ bus.op;
          carry_d    = bus.a_sign ^ bus.b_sign ^ bus.op;
          cnt_d      = '0;
          r_mag_d    = '0;
          r_sign_d   = 1'b0;
          overflow_d = 1'b0;
          err_d      = 1'b0;
          state_d    = P1;
          if (in_bad) begin
            err_d   = 1'b1;
            state_d = FIN;
          end
        end else if (state_q == FIN) begin
          state_d = IDLE;
        end
      end

      P1: begin
        r_mag_d[cnt_q*DIGIT_W +: DIGIT_W] = add_s;
        carry_d = add_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_dig) begin
          cnt_d = '0;
          if (!eff_q) begin
            r_sign_d   = a_sign_q;
            overflow_d = add_cout;
            state_d    = FIN;
          end else if (add_cout) begin
            r_sign_d = a_sign_q;
            state_d  = FIN;
          end else begin
            // No end-around carry: magnitude is held in ten's complement.
            r_sign_d = ~a_sign_q;
            carry_d  = 1'b1;
            state_d  = P2;
          end
        end
      end

      P2: begin
        r_mag_d[cnt_q*DIGIT_W +: DIGIT_W] = add_s;
        carry_d = add_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_dig) begin
          cnt_d   = '0;
          state_d = FIN;
        end
      end

      default: state_d = IDLE;
    endcase

    if ((state_d == FIN) && (r_mag_d == '0)) r_sign_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_sign_q   <= 1'b0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      eff_q      <= 1'b0;
      carry_q    <= 1'b0;
      r_mag_q    <= '0;
      r_sign_q   <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_sign_q   <= a_sign_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      eff_q      <= eff_d;
      carry_q    <= carry_d;
      r_mag_q    <= r_mag_d;
      r_sign_q   <= r_sign_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign bus.busy     = (state_q == P1) || (state_q == P2);
  assign bus.done     = (state_q == FIN);
  assign bus.r_sign   = r_sign_q;
  assign bus.r_mag    = r_mag_q;
  assign bus.overflow = overflow_q;
  assign bus.err      = err_q;

endmodule

`default_nettype wire
